pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. Drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Detects Tuse/Tnew read-after-write hazards and tracks multiply/divide occupancy with an internal countdown. Applies exception/ERET flushes signalled by CP0 at the MEM stage.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_mdu_busy_counter.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 90 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline stall/flush controller.
// Holds the Tuse "not used" code, MDU latency defaults and the countdown width.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;
    localparam int         CNT_W           = 4;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // True when one ID source operand must wait on the EX or MEM producer.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] rx_ex,
        input logic [1:0] tnew_ex,
        input logic [4:0] rx_mem,
        input logic [1:0] tnew_mem
    );
        logic hit;
        hit = 1'b0;
        if (src != 5'd0 && tuse != TUSE_NONE) begin
            if (src == rx_ex && tuse < tnew_ex)
                hit = 1'b1;
            if (src == rx_mem && tuse < tnew_mem)
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_busy_counter.sv
// Multiply/divide occupancy countdown; MDU_Busy is high while the count is non-zero.
// A start in the busy state reloads, so a stray issue never leaves a stale count.
module mdu_busy_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    mdu_state_e       w_state;
    logic [CNT_W-1:0] w_load;

    assign w_state = (r_cnt == '0) ? MDU_IDLE : MDU_BUSY;
    assign w_load  = i_div ? DIV_LOAD : MULT_LOAD;
    assign o_busy  = (w_state == MDU_BUSY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            case (w_state)
                MDU_IDLE: if (i_start) r_cnt <= w_load;
                MDU_BUSY: r_cnt <= i_start ? w_load : r_cnt - 1'b1;
                default:  r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: RAW and MDU
// stalls, CP0 exception/eret flushes, and a stall performance counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic [1:0]  Tuse_Rs_ID,
    input  logic [1:0]  Tuse_Rt_ID,
    input  logic [4:0]  Rx_EX,
    input  logic [4:0]  Rx_MEM,
    input  logic [1:0]  Tnew_EX,
    input  logic [1:0]  Tnew_MEM,
    input  logic        MDU_Use_ID,
    input  logic        MDU_Start_EX,
    input  logic        MDU_Div_EX,
    input  logic        Exc_MEM,
    input  logic        Eret_MEM,
    output logic        En_PC,
    output logic        En_IF_ID,
    output logic        Clr_IF_ID,
    output logic        Clr_ID_EX,
    output logic        Clr_EX_MEM,
    output logic        Clr_MEM_WB,
    output logic        MDU_Start_Ok,
    output logic        MDU_Busy,
    output logic [31:0] Stall_Count
);

    logic        w_stall_raw;
    logic        w_stall_mdu;
    logic        w_stall;
    logic        w_flush;
    logic [31:0] r_stall_count;

    assign w_stall_raw = src_hazard(Rs_ID, Tuse_Rs_ID, Rx_EX, Tnew_EX, Rx_MEM, Tnew_MEM)
                       | src_hazard(Rt_ID, Tuse_Rt_ID, Rx_EX, Tnew_EX, Rx_MEM, Tnew_MEM);
    assign w_stall_mdu = MDU_Use_ID && (MDU_Busy || MDU_Start_EX);
    assign w_stall     = w_stall_raw || w_stall_mdu;
    assign w_flush     = Exc_MEM || Eret_MEM;

    // A flushed EX-stage mult/div must never reach the MDU.
    assign MDU_Start_Ok = MDU_Start_EX && !w_flush;

    always_comb begin
        En_PC      = 1'b1;
        En_IF_ID   = 1'b1;
        Clr_IF_ID  = 1'b0;
        Clr_ID_EX  = 1'b0;
        Clr_EX_MEM = 1'b0;
        Clr_MEM_WB = 1'b0;
        if (w_flush) begin
            Clr_IF_ID  = 1'b1;
            Clr_ID_EX  = 1'b1;
            Clr_EX_MEM = 1'b1;
            // eret commits nothing itself; an excepting instruction is killed.
            Clr_MEM_WB = Exc_MEM;
        end else if (w_stall) begin
            En_PC     = 1'b0;
            En_IF_ID  = 1'b0;
            Clr_ID_EX = 1'b1;
        end
    end

    mdu_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_busy_counter (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_start (MDU_Start_Ok),
        .i_div   (MDU_Div_EX),
        .o_busy  (MDU_Busy)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            r_stall_count <= '0;
        else if (w_stall && !w_flush)
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign Stall_Count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a behavioural reference model
// checked every cycle plus hand-computed expectations for key scenarios.
module tb_pipe_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic [4:0]  Rs_ID, Rt_ID, Rx_EX, Rx_MEM;
    logic [1:0]  Tuse_Rs_ID, Tuse_Rt_ID, Tnew_EX, Tnew_MEM;
    logic        MDU_Use_ID, MDU_Start_EX, MDU_Div_EX, Exc_MEM, Eret_MEM;
    logic        En_PC, En_IF_ID, Clr_IF_ID, Clr_ID_EX, Clr_EX_MEM, Clr_MEM_WB;
    logic        MDU_Start_Ok, MDU_Busy;
    logic [31:0] Stall_Count;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Tuse_Rs_ID(Tuse_Rs_ID), .Tuse_Rt_ID(Tuse_Rt_ID),
        .Rx_EX(Rx_EX), .Rx_MEM(Rx_MEM),
        .Tnew_EX(Tnew_EX), .Tnew_MEM(Tnew_MEM),
        .MDU_Use_ID(MDU_Use_ID), .MDU_Start_EX(MDU_Start_EX), .MDU_Div_EX(MDU_Div_EX),
        .Exc_MEM(Exc_MEM), .Eret_MEM(Eret_MEM),
        .En_PC(En_PC), .En_IF_ID(En_IF_ID),
        .Clr_IF_ID(Clr_IF_ID), .Clr_ID_EX(Clr_ID_EX),
        .Clr_EX_MEM(Clr_EX_MEM), .Clr_MEM_WB(Clr_MEM_WB),
        .MDU_Start_Ok(MDU_Start_Ok), .MDU_Busy(MDU_Busy),
        .Stall_Count(Stall_Count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_busy_left;
    logic [31:0] m_stalls;

    function automatic bit model_stall(input int busy_left);
        bit raw;
        logic [4:0] srcs [2];
        logic [1:0] uses [2];
        srcs[0] = Rs_ID; srcs[1] = Rt_ID;
        uses[0] = Tuse_Rs_ID; uses[1] = Tuse_Rt_ID;
        raw = 0;
        for (int s = 0; s < 2; s++) begin
            if (srcs[s] != 0 && uses[s] != 3) begin
                if (srcs[s] == Rx_EX && int'(uses[s]) < int'(Tnew_EX)) raw = 1;
                if (srcs[s] == Rx_MEM && int'(uses[s]) < int'(Tnew_MEM)) raw = 1;
            end
        end
        return raw || (MDU_Use_ID && (busy_left > 0 || MDU_Start_EX));
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_busy_left <= 0;
            m_stalls    <= 32'd0;
        end else begin
            if (MDU_Start_EX && !(Exc_MEM || Eret_MEM))
                m_busy_left <= MDU_Div_EX ? 10 : 5;
            else if (m_busy_left > 0)
                m_busy_left <= m_busy_left - 1;
            if (model_stall(m_busy_left) && !(Exc_MEM || Eret_MEM))
                m_stalls <= m_stalls + 32'd1;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            bit fl, st;
            logic [7:0] exp_v, act_v;
            fl = Exc_MEM || Eret_MEM;
            st = model_stall(m_busy_left);
            exp_v = {fl || !st, fl || !st, fl, fl || st, fl, Exc_MEM,
                     MDU_Start_EX && !fl, m_busy_left > 0};
            act_v = {En_PC, En_IF_ID, Clr_IF_ID, Clr_ID_EX, Clr_EX_MEM, Clr_MEM_WB,
                     MDU_Start_Ok, MDU_Busy};
            chk("model_outs", 32'(act_v), 32'(exp_v));
            chk("model_stall_count", Stall_Count, m_stalls);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs_ID = 0; Rt_ID = 0; Rx_EX = 0; Rx_MEM = 0;
        Tuse_Rs_ID = 2'd3; Tuse_Rt_ID = 2'd3; Tnew_EX = 0; Tnew_MEM = 0;
        MDU_Use_ID = 0; MDU_Start_EX = 0; MDU_Div_EX = 0; Exc_MEM = 0; Eret_MEM = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Rst_n = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
    endtask

    initial begin
        int stalls;
        int busy_cycles;
        logic [31:0] sc_before;

        clear_inputs();
        Tuse_Rs_ID = 0; Tuse_Rt_ID = 0;
        #2 Rst_n = 1'b0;
        cmp_en = 1'b1;
        step();
        #1;
        chk("reset_en_pc", En_PC, 1);
        chk("reset_clears", {Clr_IF_ID, Clr_ID_EX, Clr_EX_MEM, Clr_MEM_WB}, 0);
        chk("reset_busy", MDU_Busy, 0);
        chk("reset_start_ok", MDU_Start_Ok, 0);
        chk("reset_stall_count", Stall_Count, 0);
        step();
        Rst_n = 1'b1;
        step();

        // lw $t0 in EX, add in ID reads $t0 next cycle
        Rs_ID = 8; Tuse_Rs_ID = 1; Rx_EX = 8; Tnew_EX = 2;
        #1;
        chk("raw_en_pc", En_PC, 0);
        chk("raw_clr_id_ex", Clr_ID_EX, 1);
        step();
        Rx_EX = 0; Tnew_EX = 0; Rx_MEM = 8; Tnew_MEM = 1;
        #1;
        chk("raw_release", En_PC, 1);
        chk("raw_stall_count", Stall_Count, 1);
        step();
        Rx_MEM = 0; Rx_EX = 0; Tnew_EX = 2;
        #1;
        chk("raw_rx_zero", En_PC, 1);
        step();
        Rs_ID = 0; Rx_EX = 0; Tnew_EX = 2;
        Rt_ID = 9; Tuse_Rt_ID = 0; Rx_MEM = 9; Tnew_MEM = 1;
        #1;
        chk("raw_rt_mem", Clr_ID_EX, 1);
        step();
        Rt_ID = 9; Tuse_Rt_ID = 3;
        #1;
        chk("raw_tuse_none", En_PC, 1);
        step();

        // mult then mflo held in ID
        do_reset();
        MDU_Start_EX = 1; MDU_Div_EX = 0; MDU_Use_ID = 1;
        #1;
        chk("mult_start_ok", MDU_Start_Ok, 1);
        stalls = (En_PC == 0) ? 1 : 0;
        step();
        MDU_Start_EX = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (En_PC != 0) break;
            stalls++;
            step();
        end
        chk("mult_stall_cycles", stalls, 6);
        chk("mult_busy_fell", MDU_Busy, 0);
        chk("mult_stall_count", Stall_Count, 6);
        step();

        // div: busy width
        clear_inputs();
        MDU_Start_EX = 1; MDU_Div_EX = 1;
        step();
        MDU_Start_EX = 0;
        busy_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (!MDU_Busy) break;
            busy_cycles++;
            step();
        end
        chk("div_busy_cycles", busy_cycles, 10);

        // reload while busy: mult then div
        step();
        MDU_Start_EX = 1; MDU_Div_EX = 0;
        step();
        MDU_Div_EX = 1;
        step();
        MDU_Start_EX = 0;
        for (int k = 0; k < 12; k++) step();
        #1;
        chk("reload_busy_tail", MDU_Busy, 0);
        step();

        // exception while RAW stall and MDU start in EX
        sc_before = Stall_Count;
        Rs_ID = 8; Tuse_Rs_ID = 1; Rx_EX = 8; Tnew_EX = 2;
        MDU_Start_EX = 1; MDU_Div_EX = 1; Exc_MEM = 1;
        #1;
        chk("exc_clears", {Clr_IF_ID, Clr_ID_EX, Clr_EX_MEM, Clr_MEM_WB}, 4'hF);
        chk("exc_en_pc", En_PC, 1);
        chk("exc_start_ok", MDU_Start_Ok, 0);
        step();
        clear_inputs();
        #1;
        chk("exc_no_busy", MDU_Busy, 0);
        chk("exc_stall_count", Stall_Count, sc_before);

        // eret, then both together
        Eret_MEM = 1;
        #1;
        chk("eret_clears", {Clr_IF_ID, Clr_ID_EX, Clr_EX_MEM, Clr_MEM_WB}, 4'hE);
        step();
        Exc_MEM = 1;
        #1;
        chk("exc_eret_memwb", Clr_MEM_WB, 1);
        step();

        // asynchronous reset mid-divide with mflo waiting
        clear_inputs();
        MDU_Start_EX = 1; MDU_Div_EX = 1;
        step();
        MDU_Start_EX = 0; MDU_Use_ID = 1;
        step(); step(); step();
        #1;
        chk("middiv_busy", MDU_Busy, 1);
        chk("middiv_stall", En_PC, 0);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("arst_busy", MDU_Busy, 0);
        chk("arst_en_pc", En_PC, 1);
        chk("arst_stall_count", Stall_Count, 0);
        step();
        Rst_n = 1'b1;
        step();
        #1;
        chk("post_rst_no_stall", En_PC, 1);
        step();
        step();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
